// File: rtl/wb_sram_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM controller.
// Bus widths normally come from the project-wide config; defaults keep this slice self-contained.
`ifndef WB_ADDR_W
`define WB_ADDR_W 24
`endif
`ifndef RW
`define RW 16
`endif

package wb_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int BEAT_W = 4;
  localparam int CNT_W  = 3;

  localparam logic [BEAT_W-1:0] BEATS_8 = 4'd8;
  localparam logic [BEAT_W-1:0] BEATS_4 = 4'd4;
  localparam logic [BEAT_W-1:0] BEATS_1 = 4'd1;

  // Beat count requested by the burst bits; 8-burst wins if both are set,
  // but that combination is rejected as an error before it is ever used.
  function automatic logic [BEAT_W-1:0] burst_beats(input logic b8, input logic b4);
    if (b8) return BEATS_8;
    if (b4) return BEATS_4;
    return BEATS_1;
  endfunction

endpackage

// File: rtl/wb_sram_ctrl_if.sv
// Wishbone slave-side bundle for the SRAM controller.
// Handshake: a request is valid while cyc & stb are high; the controller is
// ready only in IDLE, so the request is taken at the first edge it sees it there.
// Each beat completes with a one-cycle ack; a rejected request completes with a
// single one-cycle err instead. Dropping cyc abandons the transfer silently.
interface wb_sram_ctrl_if;
  logic                  i_wb_cyc;
  logic                  i_wb_stb;
  logic [`WB_ADDR_W-1:0] i_wb_adr;
  logic [`RW-1:0]        i_wb_dat;
  logic                  i_wb_we;
  logic [1:0]            i_wb_sel;
  logic                  i_wb_8_burst;
  logic                  i_wb_4_burst;
  logic [`RW-1:0]        o_wb_dat;
  logic                  o_wb_ack;
  logic                  o_wb_err;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_adr, i_wb_dat, i_wb_we, i_wb_sel,
           i_wb_8_burst, i_wb_4_burst,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_adr, i_wb_dat, i_wb_we, i_wb_sel,
           i_wb_8_burst, i_wb_4_burst,
    output o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/wb_burst_addr.sv
// Beat counter and wrapping burst address. The increment wraps inside the
// aligned 8- or 4-word block so a line fill can start at the critical word.
module wb_burst_addr
  import wb_sram_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [MEM_ADDR_W-1:0] i_adr,
  input  logic [BEAT_W-1:0]     i_beats,
  input  logic                  i_step,
  output logic [MEM_ADDR_W-1:0] o_adr,
  output logic                  o_last
);

  logic [MEM_ADDR_W-1:0] adr_q;
  logic [MEM_ADDR_W-1:0] wrap_mask_q;
  logic [MEM_ADDR_W-1:0] adr_inc;
  logic [BEAT_W-1:0]     beats_q;

  assign adr_inc = adr_q + MEM_ADDR_W'(1);
  assign o_adr   = adr_q;
  assign o_last  = (beats_q <= BEAT_W'(1));

  // Load a new transfer, or advance one beat with the low bits wrapping under the mask.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      adr_q       <= '0;
      wrap_mask_q <= '0;
      beats_q     <= '0;
    end else if (i_load) begin
      adr_q       <= i_adr;
      wrap_mask_q <= MEM_ADDR_W'(i_beats - BEAT_W'(1));
      beats_q     <= i_beats;
    end else if (i_step) begin
      adr_q   <= (adr_q & ~wrap_mask_q) | (adr_inc & wrap_mask_q);
      beats_q <= beats_q - BEAT_W'(1);
    end
  end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone slave driving an asynchronous SRAM with a programmable number of
// extra access cycles per beat and wrapping 4/8-beat read bursts.
module wb_sram_ctrl
  import wb_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYC   = 1,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  wb_sram_ctrl_if.slave         wb,
  output logic [MEM_ADDR_W-1:0] o_mem_adr,
  output logic [`RW-1:0]        o_mem_dat,
  input  logic [`RW-1:0]        i_mem_dat,
  output logic                  o_mem_oe,
  output logic                  o_mem_we,
  output logic [1:0]            o_mem_be,
  output state_t                o_dbg_state
);

  state_t state_q, state_d;

  logic                  we_q;
  logic [`RW-1:0]        mem_dat_q;
  logic [1:0]            be_q;
  logic [`RW-1:0]        rdat_q;
  logic                  ack_q, err_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  ack_d, err_d;
  logic                  accept, cnt_load, cnt_dec, capture, step;
  logic                  req_valid, req_bad;
  logic [`WB_ADDR_W-1:0] adr_hi;
  logic                  burst_last;

  assign req_valid = wb.i_wb_cyc & wb.i_wb_stb;
  // Any address bit above the SRAM window makes the request out of range.
  assign adr_hi    = wb.i_wb_adr >> MEM_ADDR_W;
  assign req_bad   = (|adr_hi)
                   | ((wb.i_wb_8_burst | wb.i_wb_4_burst) & wb.i_wb_we)
                   | (wb.i_wb_8_burst & wb.i_wb_4_burst);

  wb_burst_addr #(
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_burst_addr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (accept),
    .i_adr   (wb.i_wb_adr[MEM_ADDR_W-1:0]),
    .i_beats (burst_beats(wb.i_wb_8_burst, wb.i_wb_4_burst)),
    .i_step  (step),
    .o_adr   (o_mem_adr),
    .o_last  (burst_last)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    accept   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    capture  = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            accept   = 1'b1;
            cnt_load = 1'b1;
            state_d  = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!wb.i_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          capture = ~we_q;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (!wb.i_wb_cyc || err_q || burst_last) begin
          state_d = ST_IDLE;
        end else begin
          step     = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request registers, wait counter, read-data capture and registered responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q      <= 1'b0;
      mem_dat_q <= '0;
      be_q      <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      if (accept) begin
        we_q      <= wb.i_wb_we;
        mem_dat_q <= wb.i_wb_dat;
        be_q      <= wb.i_wb_sel;
      end
      if (cnt_load)     cnt_q <= CNT_W'(WAIT_CYC);
      else if (cnt_dec) cnt_q <= cnt_q - CNT_W'(1);
      if (capture) rdat_q <= i_mem_dat;
    end
  end

  // SRAM strobes follow the ACCESS state; a dropped cyc masks any pending response.
  assign o_mem_oe    = (state_q == ST_ACCESS) & ~we_q;
  assign o_mem_we    = (state_q == ST_ACCESS) &  we_q;
  assign o_mem_dat   = mem_dat_q;
  assign o_mem_be    = be_q;
  assign wb.o_wb_dat = rdat_q;
  assign wb.o_wb_ack = ack_q & wb.i_wb_cyc;
  assign wb.o_wb_err = err_q & wb.i_wb_cyc;
  assign o_dbg_state = state_q;

endmodule
